// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: trap/stall/redirect priority, misaligned-target
// rejection, and an optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen #(
  parameter int unsigned XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned INC       = 4,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_seq,
  output logic            misalign,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned LOW = $clog2(INC);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            trap_bad, redir_bad;

  assign pc_seq    = pc_q + XLEN'(INC);
  assign pc_out    = pc_q;
  assign misalign  = misalign_q;
  assign trap_bad  = |trap_target[LOW-1:0];
  assign redir_bad = |redirect_target[LOW-1:0];

`ifdef PC_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]   tp_q, tp_d, tp_inc, tp_dec;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            has_entry, push_ok;

  // tp_q points at the current top entry; the buffer wraps so a push when
  // full silently overwrites the oldest return address.
  assign tp_inc    = (tp_q == PW'(RAS_DEPTH - 1)) ? '0 : tp_q + 1'b1;
  assign tp_dec    = (tp_q == '0) ? PW'(RAS_DEPTH - 1) : tp_q - 1'b1;
  assign has_entry = (cnt_q != '0);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
  assign push_ok   = call && !stall && !trap_valid && !(redirect_valid && redir_bad);

  always_comb begin
    pc_d       = pc_seq;
    misalign_d = 1'b0;
    ras_d      = ras_q;
    tp_d       = tp_q;
    cnt_d      = cnt_q;
    if (trap_valid) begin
      if (trap_bad) begin
        pc_d       = pc_q;
        misalign_d = 1'b1;
      end else begin
        pc_d  = trap_target;
        cnt_d = '0;
      end
    end else if (stall) begin
      pc_d = pc_q;
    end else if (redirect_valid && redir_bad) begin
      pc_d       = pc_q;
      misalign_d = 1'b1;
    end else begin
      if (redirect_valid)
        pc_d = redirect_target;
      else if (ret && has_entry)
        pc_d = ras_q[tp_q];
      // call+ret with a live top swaps the top in place; count unchanged
      if (push_ok && ret && !redirect_valid && has_entry) begin
        ras_d[tp_q] = pc_seq;
      end else if (push_ok) begin
        ras_d[tp_inc] = pc_seq;
        tp_d          = tp_inc;
        if (!ras_full) cnt_d = cnt_q + 1'b1;
      end else if (ret && !redirect_valid && has_entry) begin
        tp_d  = tp_dec;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
    ras_q <= ras_d;
  end
`else
  logic unused_ras;
  assign unused_ras = ^{call, ret};
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;

  always_comb begin
    pc_d       = pc_seq;
    misalign_d = 1'b0;
    if (trap_valid) begin
      if (trap_bad) begin
        pc_d       = pc_q;
        misalign_d = 1'b1;
      end else begin
        pc_d = trap_target;
      end
    end else if (stall) begin
      pc_d = pc_q;
    end else if (redirect_valid) begin
      if (redir_bad) begin
        pc_d       = pc_q;
        misalign_d = 1'b1;
      end else begin
        pc_d = redirect_target;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
